// File: rtl/sr_ctrl_pkg.sv
// ============================================================================
//  Module   : sr_ctrl_pkg
//  Purpose  : Shared types and constants for the RS-latch controller:
//             FSM state encoding, phase-counter width, default timing and
//             the latch result check.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sr_ctrl_pkg;

  // Width of the per-phase cycle counter; timing parameters must fit in it.
  localparam int CNT_W = 4;

  // Default number of cycles the selected latch input is driven high.
  localparam int DEF_PULSE_CYC = 2;

  // Default number of quiet cycles before the latch outputs are sampled.
  localparam int DEF_SETTLE_CYC = 2;

  // Controller FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // True when the latch shows the state the operation asked for:
  // q equal to the op and qbar its complement.
  function automatic logic latch_ok(input logic q, input logic qbar,
                                    input logic want);
    return (q == want) && (qbar == ~want);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. The search starts at the
//             requester after last_grant and wraps; the first active
//             request wins. Returns one-hot grant, its index and a valid.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the requesters in rotating order from last_grant+1; keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last_grant) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sr_latch_ctrl.sv
// ============================================================================
//  Module   : sr_latch_ctrl
//  Purpose  : Shares one external RS latch between N_REQ requesters. A
//             granted request drives s or r for PULSE_CYC cycles, lets the
//             latch settle for SETTLE_CYC cycles, checks q/qbar and returns
//             a one-cycle ack with an error flag to the requester.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  output logic [N_REQ-1:0] ack,
  output logic             err,
  output logic             busy,
  output logic             s_out,
  output logic             r_out,
  input  logic             q_in,
  input  logic             qbar_in
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [N_REQ-1:0] grant_q;
  logic [IDX_W-1:0] last_grant_q;
  logic             op_q;
  logic             s_out_q;
  logic             r_out_q;
  logic [N_REQ-1:0] ack_q;
  logic             err_q;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic             pass_d;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .valid      (arb_valid)
  );

  // Latch result as seen this cycle against the operation in flight.
  assign pass_d = latch_ok(q_in, qbar_in, op_q);

  // Controller FSM; s/r, ack and err are all registered here so that s and r
  // can only ever be set from a single op bit and are cleared together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_idx_q  <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      op_q         <= 1'b0;
      s_out_q      <= 1'b0;
      r_out_q      <= 1'b0;
      ack_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_idx_q <= arb_idx;
            grant_q     <= arb_grant;
            op_q        <= op[arb_idx];
            s_out_q     <= op[arb_idx];
            r_out_q     <= ~op[arb_idx];
            cnt_q       <= CNT_W'(PULSE_CYC - 1);
            state_q     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == '0) begin
            s_out_q <= 1'b0;
            r_out_q <= 1'b0;
            cnt_q   <= CNT_W'(SETTLE_CYC - 1);
            state_q <= ST_SETTLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            cnt_q   <= '0;
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_CHECK: begin
          ack_q   <= grant_q;
          err_q   <= ~pass_d;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          ack_q        <= '0;
          err_q        <= 1'b0;
          last_grant_q <= grant_idx_q;
          state_q      <= ST_IDLE;
        end
        default: begin
          s_out_q <= 1'b0;
          r_out_q <= 1'b0;
          ack_q   <= '0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign s_out = s_out_q;
  assign r_out = r_out_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_ctrl.sv
// ============================================================================
//  Module   : tb_sr_latch_ctrl
//  Purpose  : Bench for sr_latch_ctrl driving a behavioural RS latch with
//             1-unit gate delays; a transaction-level model predicts every
//             output each cycle, directed tests pin the model with literals.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sr_latch_ctrl;

  localparam int N = 4;
  localparam int P = 2;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] op  = '0;
  wire  [N-1:0] ack;
  wire          err;
  wire          busy;
  wire          s_out;
  wire          r_out;

  // External latch state and an override that pins q low for fault tests.
  logic lq = 1'b0;
  logic lqb = 1'b1;
  logic fault_en = 1'b0;
  wire  q_in    = fault_en ? 1'b0 : lq;
  wire  qbar_in = lqb;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  chk_en   = 1'b0;

  always #5 clk = ~clk;

  sr_latch_ctrl #(
    .N_REQ      (N),
    .PULSE_CYC  (P),
    .SETTLE_CYC (S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op      (op),
    .ack     (ack),
    .err     (err),
    .busy    (busy),
    .s_out   (s_out),
    .r_out   (r_out),
    .q_in    (q_in),
    .qbar_in (qbar_in)
  );

  // Cross-coupled NOR latch: the driven gate flips after one unit, the other after two.
  always @(s_out or r_out) begin
    if (s_out === 1'b1 && r_out !== 1'b1) begin
      #1 lqb = 1'b0;
      #1 lq  = 1'b1;
    end else if (r_out === 1'b1 && s_out !== 1'b1) begin
      #1 lq  = 1'b0;
      #1 lqb = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction model: one outstanding transaction, m_t counts cycles since grant.
  // Cycles 1..P drive, P+1..P+S quiet, P+S+1 check, P+S+2 ack.
  bit m_active = 1'b0;
  int m_t      = 0;
  int m_idx    = 0;
  bit m_op     = 1'b0;
  int m_last   = N - 1;
  bit m_pass   = 1'b0;

  always @(posedge clk) begin
    int i;
    if (rst) begin
      m_active = 1'b0;
      m_t      = 0;
      m_last   = N - 1;
    end else if (!m_active) begin
      for (int k = 1; k <= N; k++) begin
        i = (m_last + k) % N;
        if (!m_active && req[2'(i)]) begin
          m_active = 1'b1;
          m_t      = 1;
          m_idx    = i;
          m_op     = op[2'(i)];
        end
      end
    end else begin
      if (m_t == P + S + 1)
        m_pass = (q_in === m_op) && (qbar_in === !m_op);
      if (m_t == P + S + 2) begin
        m_active = 1'b0;
        m_last   = m_idx;
      end else begin
        m_t++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit drive, done;
    if (chk_en) begin
      drive = m_active && (m_t <= P);
      done  = m_active && (m_t == P + S + 2);
      chk("busy",  int'(busy),  int'(m_active));
      chk("s_out", int'(s_out), int'(drive && m_op));
      chk("r_out", int'(r_out), int'(drive && !m_op));
      chk("ack",   int'(ack),   done ? (1 << m_idx) : 0);
      chk("err",   int'(err),   int'(done && !m_pass));
      chk("s_r_overlap", int'(s_out & r_out), 0);
      chk("ack_onehot0", int'($onehot0(ack)), 1);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one request from the IDLE state and wait for its ack; lat counts
  // cycles with the request cycle as cycle 1.
  task automatic run_txn(input logic [N-1:0] r, input logic [N-1:0] o,
                         output int idx, output int e, output int lat,
                         output int scnt, output int rcnt);
    bit got;
    got = 1'b0;
    req = r; op = o;
    idx = -1; e = 0; lat = 1; scnt = 0; rcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      scnt += int'(s_out);
      rcnt += int'(r_out);
      if (ack != '0) begin
        idx = $clog2(ack);
        e   = int'(err);
        got = 1'b1;
        break;
      end
    end
    req = '0;
    chk("txn_acked", int'(got), 1);
    @(negedge clk);
  endtask

  int idx, e, lat, scnt, rcnt;
  int order[$];
  int acks_seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_busy",  int'(busy),  0);
    chk("rst_s_out", int'(s_out), 0);
    chk("rst_r_out", int'(r_out), 0);
    chk("rst_ack",   int'(ack),   0);
    chk("rst_err",   int'(err),   0);

    // Single set from requester 0 with the latch at 0.
    run_txn(4'b0001, 4'b0001, idx, e, lat, scnt, rcnt);
    chk("set_idx",  idx,  0);
    chk("set_err",  e,    0);
    chk("set_lat",  lat,  7);
    chk("set_scnt", scnt, 2);
    chk("set_rcnt", rcnt, 0);
    chk("set_q",    int'(lq), 1);

    // Round-robin with all requesters asserting continuously from reset.
    do_reset();
    req = 4'b1111; op = 4'b0101;
    order.delete();
    for (int c = 0; c < 100 && order.size() < 5; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        order.push_back($clog2(ack));
        chk("rr_err", int'(err), 0);
      end
    end
    req = '0;
    chk("rr_count", order.size(), 5);
    if (order.size() == 5) begin
      chk("rr_g0", order[0], 0);
      chk("rr_g1", order[1], 1);
      chk("rr_g2", order[2], 2);
      chk("rr_g3", order[3], 3);
      chk("rr_g4", order[4], 0);
    end
    @(negedge clk);
    chk("rr_q", int'(lq), 1);

    // Fault: q forced low while requester 2 sets.
    do_reset();
    fault_en = 1'b1;
    run_txn(4'b0100, 4'b0100, idx, e, lat, scnt, rcnt);
    chk("fault_idx",  idx, 2);
    chk("fault_err",  e,   1);
    chk("fault_idle", int'(busy), 0);
    fault_en = 1'b0;

    // Reset during the second DRIVE cycle aborts without ack.
    do_reset();
    req = 4'b0001; op = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_r_before", int'(r_out), 1);
    rst = 1'b1; req = '0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_s_out", int'(s_out), 0);
    chk("abort_r_out", int'(r_out), 0);
    chk("abort_busy",  int'(busy),  0);
    rst = 1'b0;
    acks_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack != '0) acks_seen++;
    end
    chk("abort_no_ack", acks_seen, 0);

    // Drive the latch to 0, then repeat the reset request (idempotent).
    run_txn(4'b0010, 4'b0000, idx, e, lat, scnt, rcnt);
    chk("clr_idx", idx, 1);
    chk("clr_q",   int'(lq), 0);
    run_txn(4'b0010, 4'b0000, idx, e, lat, scnt, rcnt);
    chk("idem_idx",  idx,  1);
    chk("idem_err",  e,    0);
    chk("idem_rcnt", rcnt, 2);
    chk("idem_scnt", scnt, 0);
    chk("idem_q",    int'(lq), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
